priority_span_decoder: RTL and testbench

//  Decoder counterpart of the priority encoder. Takes a left/right one-hot marker pair
//  (MSB-most and LSB-most set bit of a word) and rebuilds the contiguous span mask:

---
 rtl/priority_pkg.sv | 12 +
 rtl/priority_span_decoder_onehot_to_bin.sv | 30 +++
 rtl/priority_span_decoder.sv | 99 +++++++++
 tb/tb_priority_span_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_pkg.sv
// Shared types for the priority span decoder: error codes reported alongside
// each reconstructed span mask.
package priority_pkg;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NOT_ONEHOT = 2'd1,
        ERR_HALF_EMPTY = 2'd2,
        ERR_ORDER      = 2'd3
    } span_err_t;

endpackage

// File: rtl/priority_span_decoder_onehot_to_bin.sv
// Combinational one-hot to binary index converter with empty and
// multiple-bit detection; idx is only meaningful when exactly one bit is set.
module onehot_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     zero_o,
    output logic                     multi_o
);

    localparam int IDX_W = $clog2(WIDTH);

    logic seen;

    always_comb begin
        idx_o   = '0;
        seen    = 1'b0;
        multi_o = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                idx_o   = idx_o | IDX_W'(i);
                multi_o = multi_o | seen;
                seen    = 1'b1;
            end
        end
        zero_o = ~seen;
    end

endmodule

// File: rtl/priority_span_decoder.sv
// Rebuilds a contiguous span mask from a left/right one-hot marker pair;
// two-stage valid/ready pipeline with malformed-pair error reporting.
module priority_span_decoder
    import priority_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] data_o,
    output span_err_t        err_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx_l_c, idx_r_c;
    logic             zero_l_c, zero_r_c, multi_l_c, multi_r_c;

    logic [IDX_W-1:0] idx_l, idx_r;
    logic             zero_l, zero_r, multi_l, multi_r;
    logic             s1_val;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] mask_c;
    span_err_t        err_c;

    onehot_to_bin #(.WIDTH(WIDTH)) u_left (
        .data_i  (data_left_i),
        .idx_o   (idx_l_c),
        .zero_o  (zero_l_c),
        .multi_o (multi_l_c)
    );

    onehot_to_bin #(.WIDTH(WIDTH)) u_right (
        .data_i  (data_right_i),
        .idx_o   (idx_r_c),
        .zero_o  (zero_r_c),
        .multi_o (multi_r_c)
    );

    assign s2_load      = ~data_val_o | data_ready_i;
    assign data_ready_o = ~srst_i & (~s1_val | s2_load);
    assign in_fire      = data_val_i & data_ready_o;

    always_comb begin
        mask_c = '0;
        err_c  = ERR_NONE;
        if (multi_l | multi_r) begin
            err_c = ERR_NOT_ONEHOT;
        end else if (zero_l ^ zero_r) begin
            err_c = ERR_HALF_EMPTY;
        end else if (zero_l & zero_r) begin
            err_c = ERR_NONE;
        end else if (idx_r > idx_l) begin
            err_c = ERR_ORDER;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                mask_c[i] = (i >= 32'(idx_r)) && (i <= 32'(idx_l));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            s1_val     <= 1'b0;
            data_val_o <= 1'b0;
            data_o     <= '0;
            err_o      <= ERR_NONE;
        end else begin
            if (in_fire) begin
                s1_val  <= 1'b1;
                idx_l   <= idx_l_c;
                idx_r   <= idx_r_c;
                zero_l  <= zero_l_c;
                zero_r  <= zero_r_c;
                multi_l <= multi_l_c;
                multi_r <= multi_r_c;
            end else if (s2_load) begin
                s1_val <= 1'b0;
            end
            // Output registers only move on s2_load, which holds them during a stall.
            if (s2_load) begin
                data_val_o <= s1_val;
                if (s1_val) begin
                    data_o <= mask_c;
                    err_o  <= err_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_span_decoder.sv
// Directed and randomised bench for priority_span_decoder with an in-order
// scoreboard built from an independent behavioural model.
module tb_priority_span_decoder;
    import priority_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         srst;
    logic [W-1:0] left_m, right_m;
    logic         val_i;
    logic         ready_o;
    logic [W-1:0] data_out;
    span_err_t    err_out;
    logic         val_o;
    logic         ready_i;

    always #5 clk = ~clk;

    priority_span_decoder #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .data_left_i  (left_m),
        .data_right_i (right_m),
        .data_val_i   (val_i),
        .data_ready_o (ready_o),
        .data_o       (data_out),
        .err_o        (err_out),
        .data_val_o   (val_o),
        .data_ready_i (ready_i)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   e;
        int           cyc;
        bit           chk_lat;
    } ent_t;

    ent_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    bit           fired;
    bit           stall_prev = 0;
    logic [W-1:0] hold_d;
    logic [1:0]   hold_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t model(input logic [W-1:0] l, input logic [W-1:0] r);
        ent_t   t;
        int     nl, nr, pl, pr;
        logic [15:0] hi, lo;
        nl = $countones(l);
        nr = $countones(r);
        t.d = '0;
        t.e = ERR_NONE;
        t.cyc = 0;
        t.chk_lat = 0;
        if (nl > 1 || nr > 1) begin
            t.e = ERR_NOT_ONEHOT;
        end else if ((nl == 0) != (nr == 0)) begin
            t.e = ERR_HALF_EMPTY;
        end else if (nl == 0) begin
            t.e = ERR_NONE;
        end else begin
            pl = 0;
            pr = 0;
            for (int i = 0; i < W; i++) begin
                if (l[i]) pl = i;
                if (r[i]) pr = i;
            end
            if (pr > pl) begin
                t.e = ERR_ORDER;
            end else begin
                hi = (16'h1 << (pl + 1)) - 16'h1;
                lo = (16'h1 << pr) - 16'h1;
                t.d = W'(hi & ~lo);
            end
        end
        return t;
    endfunction

    // One clock cycle: checks at the falling edge, then advances past the rising edge.
    task automatic cycle(input bit chk_lat);
        ent_t e;
        @(negedge clk);
        fired = 0;
        if (srst) begin
            check("ready_in_reset", {31'd0, ready_o}, 32'd0);
            sb.delete();
            stall_prev = 0;
        end else begin
            check("ready_o", {31'd0, ready_o}, {31'd0, !(sb.size() == 2 && !ready_i)});
            if (stall_prev) begin
                check("hold_val", {31'd0, val_o}, 32'd1);
                check("hold_data", {24'd0, data_out}, {24'd0, hold_d});
                check("hold_err", {30'd0, err_out}, {30'd0, hold_e});
            end
            if (val_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("spurious_val", {31'd0, val_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("data", {24'd0, data_out}, {24'd0, e.d});
                    check("err", {30'd0, err_out}, {30'd0, e.e});
                    if (e.chk_lat) check("latency", cyc - e.cyc, 32'd2);
                end
            end
            if (val_i && ready_o) begin
                e = model(left_m, right_m);
                e.cyc = cyc;
                e.chk_lat = chk_lat;
                sb.push_back(e);
                fired = 1;
            end
            stall_prev = val_o && !ready_i;
            hold_d = data_out;
            hold_e = err_out;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        left_m  = l;
        right_m = r;
        val_i   = 1'b1;
        ready_i = 1'b1;
        cycle(1);
        val_i   = 1'b0;
    endtask

    task automatic drain();
        int guard;
        val_i   = 1'b0;
        ready_i = 1'b1;
        guard   = 0;
        while (sb.size() > 0 && guard < 20) begin
            cycle(0);
            guard++;
        end
        check("drain_empty", sb.size(), 32'd0);
        cycle(0);
    endtask

    function automatic logic [W-1:0] rand_marker();
        logic [W-1:0] m;
        case ($urandom_range(5))
            0, 1, 2, 3: m = W'(1) << $urandom_range(W - 1);
            4:          m = '0;
            default:    m = W'($urandom);
        endcase
        return m;
    endfunction

    initial begin
        int guard;
        int n;
        logic [W-1:0] bl[8];
        logic [W-1:0] br[8];

        srst    = 1'b1;
        left_m  = '0;
        right_m = '0;
        val_i   = 1'b0;
        ready_i = 1'b1;
        cycle(0);
        cycle(0);
        srst = 1'b0;
        check("rst_val_o", {31'd0, val_o}, 32'd0);
        check("rst_data_o", {24'd0, data_out}, 32'd0);
        check("rst_err_o", {30'd0, err_out}, 32'd0);

        // Directed: spans, single-bit, empty, and each error class back to back.
        send(8'h20, 8'h04);
        send(8'h08, 8'h08);
        send(8'h00, 8'h00);
        send(8'h24, 8'h04);
        send(8'h00, 8'h01);
        send(8'h02, 8'h40);
        send(8'h80, 8'h01);
        send(8'h01, 8'h01);
        send(8'h80, 8'h80);
        drain();

        // Ignored input while valid is low.
        left_m  = 8'hFF;
        right_m = 8'h01;
        val_i   = 1'b0;
        repeat (3) cycle(0);
        check("idle_val_o", {31'd0, val_o}, 32'd0);

        // Random stream with random backpressure and occasional idle cycles.
        for (int i = 0; i < 8; i++) begin
            bl[i] = rand_marker();
            br[i] = rand_marker();
        end
        n = 0;
        guard = 0;
        while (n < 8 && guard < 400) begin
            ready_i = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) begin
                val_i   = 1'b0;
                left_m  = W'($urandom);
                right_m = W'($urandom);
            end else begin
                val_i   = 1'b1;
                left_m  = bl[n];
                right_m = br[n];
            end
            cycle(0);
            if (fired) n++;
            guard++;
        end
        check("stream_sent", n, 32'd8);
        drain();

        // Fill both stages under backpressure, then reset mid-flight.
        ready_i = 1'b0;
        val_i   = 1'b1;
        left_m  = 8'h10;
        right_m = 8'h02;
        guard   = 0;
        while (sb.size() < 2 && guard < 10) begin
            cycle(0);
            guard++;
        end
        check("inflight_two", sb.size(), 32'd2);
        check("full_ready_low", {31'd0, ready_o}, 32'd0);
        srst = 1'b1;
        cycle(0);
        srst  = 1'b0;
        val_i = 1'b0;
        check("midrst_val_o", {31'd0, val_o}, 32'd0);
        check("midrst_data_o", {24'd0, data_out}, 32'd0);
        check("midrst_err_o", {30'd0, err_out}, 32'd0);
        ready_i = 1'b1;
        cycle(0);
        check("post_rst_quiet", {31'd0, val_o}, 32'd0);
        send(8'h40, 8'h08);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
